// File: rtl/truth_table_sequencer.sv
// Truth-table sequencer: sweeps abc_out through 0..7, dwells in DRIVE
// (timed or manually stepped), captures the evaluator result f_in in a
// one-cycle CAPTURE, and compares the collected table against EXPECTED.
`timescale 1ns/1ps

module truth_table_sequencer #(
  parameter int unsigned TICKS    = 50000000,
  parameter logic [7:0]  EXPECTED = 8'b11100110
) (
  input  logic       clk_2,
  input  logic       reset,
  input  logic       start,
  input  logic       step_mode,
  input  logic       step,
  input  logic       f_in,
  output logic [2:0] abc_out,
  output logic [7:0] seg,
  output logic [7:0] table_out,
  output logic       busy,
  output logic       done,
  output logic       match
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [7:0]  SEG_VAZIO = 8'h00;
  localparam logic [7:0]  SEG_ZERO  = 8'h3f;
  localparam logic [7:0]  SEG_UM    = 8'h06;
  localparam logic [31:0] TICK_LAST = 32'(TICKS - 1);

  state_t      state;
  logic [2:0]  idx;
  logic [31:0] tick;
  logic [7:0]  table_next;
  logic        table_ok;

  // Table as it will look after the current capture; lets DONE's match
  // and seg be registered on the same edge that stores the last bit.
  always_comb begin
    table_next      = table_out;
    table_next[idx] = f_in;
    table_ok        = (table_next == EXPECTED);
  end

  // Sequencer state, counters and all registered outputs.
  always_ff @(posedge clk_2) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      tick      <= '0;
      abc_out   <= '0;
      seg       <= SEG_VAZIO;
      table_out <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      match     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= DRIVE;
            idx       <= '0;
            tick      <= '0;
            abc_out   <= '0;
            seg       <= SEG_VAZIO;
            table_out <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            match     <= 1'b0;
          end
        end

        DRIVE: begin
          if (step_mode) begin
            if (step) begin
              state <= CAPTURE;
            end
          end else if (tick == TICK_LAST) begin
            state <= CAPTURE;
          end else begin
            tick <= tick + 32'd1;
          end
        end

        CAPTURE: begin
          table_out <= table_next;
          if (idx == 3'd7) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            match <= table_ok;
            seg   <= table_ok ? SEG_UM : SEG_ZERO;
          end else begin
            state   <= DRIVE;
            idx     <= idx + 3'd1;
            abc_out <= idx + 3'd1;
            tick    <= '0;
            seg     <= f_in ? SEG_UM : SEG_ZERO;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer: randomized and directed sweeps, a
// scoreboard of expected DONE results popped by a negedge monitor.
`timescale 1ns/1ps

module tb_truth_table_sequencer;

  localparam int unsigned TK   = 2;
  localparam int          SPAN = 8 * (TK + 1);

  logic       clk_2 = 1'b0;
  logic       reset, start, step_mode, step, f_in;
  logic [2:0] abc_out;
  logic [7:0] seg, table_out;
  logic       busy, done, match;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef enum {EV_GOLDEN, EV_ZERO, EV_TABLE} ev_mode_t;
  ev_mode_t   ev_mode = EV_GOLDEN;
  logic [7:0] ev_tab  = '0;

  typedef struct {
    logic [7:0] tbl;
    logic       m;
    logic [7:0] sg;
    int         due;
    bit         timed;
  } exp_t;
  exp_t sbq[$];

  truth_table_sequencer #(.TICKS(TK)) dut (
    .clk_2     (clk_2),
    .reset     (reset),
    .start     (start),
    .step_mode (step_mode),
    .step      (step),
    .f_in      (f_in),
    .abc_out   (abc_out),
    .seg       (seg),
    .table_out (table_out),
    .busy      (busy),
    .done      (done),
    .match     (match)
  );

  always #5 clk_2 = ~clk_2;
  always @(posedge clk_2) cyc <= cyc + 1;

  // F = AB + B'C + A'BC' with {A,B,C} = i.
  function automatic logic golden_f(input logic [2:0] i);
    logic a, b, c;
    {a, b, c} = i;
    return (a & b) | (~b & c) | (~a & b & ~c);
  endfunction

  function automatic logic ref_f(input logic [2:0] i);
    case (ev_mode)
      EV_GOLDEN: return golden_f(i);
      EV_ZERO:   return 1'b0;
      default:   return ev_tab[i];
    endcase
  endfunction

  function automatic logic [7:0] seg_code(input logic b);
    return b ? 8'h06 : 8'h3f;
  endfunction

  // Evaluator under test: combinational in abc_out.
  assign f_in = (ev_mode == EV_GOLDEN) ? golden_f(abc_out) :
                (ev_mode == EV_ZERO)   ? 1'b0 : ev_tab[abc_out];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic tick1();
    @(posedge clk_2);
    #1;
  endtask

  // k = cycle in which start is presented; done expected k+1+8*(TK+1).
  task automatic push_expect(input int k, input bit timed);
    exp_t       e;
    logic [7:0] g;
    for (int i = 0; i < 8; i++) begin
      g[i]     = golden_f(3'(i));
      e.tbl[i] = ref_f(3'(i));
    end
    e.m     = (e.tbl == g);
    e.sg    = seg_code(e.m);
    e.due   = k + 1 + SPAN;
    e.timed = timed;
    sbq.push_back(e);
  endtask

  // Monitor: on each rising edge of done, pop and compare the result.
  logic done_q = 1'b0;
  always @(negedge clk_2) begin
    if (done === 1'b1 && done_q !== 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        chk("sb_table", table_out, sbq[0].tbl);
        chk("sb_match", match, sbq[0].m);
        chk("sb_seg", seg, sbq[0].sg);
        if (sbq[0].timed) chk("sb_latency", cyc, sbq[0].due);
        void'(sbq.pop_front());
      end
    end
    done_q <= done;
  end

  task automatic run_timed(input bit noise);
    int k;
    int ix;
    step_mode = 1'b0;
    start     = 1'b1;
    k         = cyc;
    push_expect(k, 1'b1);
    for (int j = 1; j <= SPAN; j++) begin
      tick1();
      ix = (j - 1) / (TK + 1);
      chk("sweep_abc", abc_out, ix);
      chk("sweep_busy", busy, 1);
      chk("sweep_done", done, 0);
      chk("sweep_seg", seg, (ix == 0) ? 8'h00 : seg_code(ref_f(3'(ix - 1))));
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      step  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    start = 1'b0;
    step  = 1'b0;
    tick1();
    chk("done_rise", done, 1);
    repeat (2) tick1();
    chk("done_hold", done, 1);
    chk("done_busy", busy, 0);
    chk("done_abc_hold", abc_out, 7);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1);
  end

  initial begin
    int k;
    int n;
    reset = 1'b1; start = 1'b0; step_mode = 1'b0; step = 1'b0;
    repeat (2) tick1();
    chk("rst_abc", abc_out, 0);
    chk("rst_seg", seg, 0);
    chk("rst_table", table_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_match", match, 0);
    reset = 1'b0;
    tick1();
    chk("idle_hold", busy, 0);

    ev_mode = EV_GOLDEN; run_timed(1'b0);
    ev_mode = EV_ZERO;   run_timed(1'b0);
    for (int r = 0; r < 4; r++) begin
      ev_mode = EV_TABLE;
      ev_tab  = 8'($urandom);
      repeat ($urandom_range(0, 3)) tick1();
      run_timed(1'b1);
    end

    // Manual stepping
    ev_mode = EV_GOLDEN; step_mode = 1'b1; step = 1'b0; start = 1'b1;
    k = cyc; push_expect(k, 1'b0);
    tick1();
    start = 1'b0;
    repeat (20) tick1();
    chk("man_abc_wait", abc_out, 0);
    chk("man_busy_wait", busy, 1);
    for (int i = 0; i < 8; i++) begin
      step = 1'b1; tick1();
      step = 1'b0; tick1();
      if (i < 7) begin
        chk("man_abc_adv", abc_out, i + 1);
        repeat (2) tick1();
        chk("man_abc_hold", abc_out, i + 1);
      end
    end
    chk("man_done", done, 1);
    step_mode = 1'b0;
    tick1();

    // Reset mid-sweep at abc_out == 4
    ev_mode = EV_GOLDEN; start = 1'b1;
    tick1();
    start = 1'b0;
    n = 0;
    while (abc_out !== 3'd4 && n < 100) begin tick1(); n++; end
    chk("reach_abc4", abc_out, 4);
    reset = 1'b1;
    tick1();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_table", table_out, 0);
    chk("mid_rst_seg", seg, 0);
    chk("mid_rst_abc", abc_out, 0);
    chk("mid_rst_done", done, 0);
    reset = 1'b0;
    tick1();

    // Start held through a sweep, then restart from DONE
    ev_mode = EV_GOLDEN; start = 1'b1;
    k = cyc;
    push_expect(k, 1'b1);
    push_expect(k + SPAN + 1, 1'b1);
    for (int j = 1; j <= 2 * SPAN + 2; j++) begin
      tick1();
      if (j <= SPAN) chk("held_busy", busy, 1);
      if (j == SPAN + 1) chk("held_done1", done, 1);
      if (j == SPAN + 2) begin
        chk("restart_busy", busy, 1);
        chk("restart_table", table_out, 0);
        chk("restart_done", done, 0);
        chk("restart_seg", seg, 0);
      end
    end
    chk("held_done2", done, 1);
    start = 1'b0;
    tick1();
    chk("held_done_stays", done, 1);

    // Step-mode to timed switch at tick == 1
    ev_mode = EV_GOLDEN; step_mode = 1'b0; start = 1'b1;
    k = cyc; push_expect(k, 1'b0);
    tick1();
    start = 1'b0;
    tick1();
    step_mode = 1'b1;
    repeat (5) tick1();
    chk("sw_abc_hold", abc_out, 0);
    chk("sw_busy", busy, 1);
    step_mode = 1'b0;
    tick1();
    chk("sw_capture_abc", abc_out, 0);
    tick1();
    chk("sw_next_abc", abc_out, 1);
    chk("sw_seg", seg, seg_code(golden_f(3'd0)));
    n = 0;
    while (done !== 1'b1 && n < 100) begin tick1(); n++; end
    chk("sw_done", done, 1);

    repeat (5) tick1();
    chk("sb_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
